// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants and types for the multicycle control unit (package cu_pkg).
package cu_pkg;

    localparam logic [6:0] OPCODE_R     = 7'b0110011;
    localparam logic [6:0] OPCODE_I     = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [6:0] OPCODE_B     = 7'b1100011;
    localparam logic [6:0] OPCODE_J     = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    localparam logic [2:0] IMM_NF = 3'd0;
    localparam logic [2:0] IMM_I  = 3'd1;
    localparam logic [2:0] IMM_S  = 3'd2;
    localparam logic [2:0] IMM_B  = 3'd3;
    localparam logic [2:0] IMM_J  = 3'd4;

    localparam logic [1:0] PC_4      = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, ERROR} cu_state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_ADD, CL_SUB, CL_ADDI, CL_BEQ, CL_BNE, CL_JAL, CL_LW, CL_SW
    } instr_class_e;

    function automatic logic [2:0] imm_of_class(instr_class_e c);
        case (c)
            CL_ADDI, CL_LW: return IMM_I;
            CL_SW:          return IMM_S;
            CL_BEQ, CL_BNE: return IMM_B;
            CL_JAL:         return IMM_J;
            default:        return IMM_NF;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: memory handshakes in, datapath controls out.
// Optional illegal_o exists only when CU_ILLEGAL_TRAP_EN is defined.
interface cu_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_CTRL_W = 4
) ();
    logic [31:0]           instr_i;
    logic                  imem_ack_i;
    logic                  dmem_ack_i;
    logic                  alu_zero_i;
    logic                  imem_req_o;
    logic                  ir_write_o;
    logic                  pc_write_o;
    logic [1:0]            pc_sel_o;
    logic                  regwrite_o;
    logic [REG_ADDR_W-1:0] rd_o;
    logic [REG_ADDR_W-1:0] rs1_o;
    logic [REG_ADDR_W-1:0] rs2_o;
    logic                  memread_o;
    logic                  memwrite_o;
    logic                  memtoreg_o;
    logic                  alusrc_r1_o;
    logic                  alusrc_r2_o;
    logic [ALU_CTRL_W-1:0] alucontrol_o;
    logic [2:0]            imm_type_o;
    logic                  busy_o;
    logic                  err_o;
`ifdef CU_ILLEGAL_TRAP_EN
    logic                  illegal_o;
`endif

    modport master (
        input  instr_i, imem_ack_i, dmem_ack_i, alu_zero_i,
        output imem_req_o, ir_write_o, pc_write_o, pc_sel_o, regwrite_o, rd_o, rs1_o, rs2_o,
               memread_o, memwrite_o, memtoreg_o, alusrc_r1_o, alusrc_r2_o, alucontrol_o,
               imm_type_o, busy_o, err_o
`ifdef CU_ILLEGAL_TRAP_EN
        , illegal_o
`endif
    );

    modport slave (
        output instr_i, imem_ack_i, dmem_ack_i, alu_zero_i,
        input  imem_req_o, ir_write_o, pc_write_o, pc_sel_o, regwrite_o, rd_o, rs1_o, rs2_o,
               memread_o, memwrite_o, memtoreg_o, alusrc_r1_o, alusrc_r2_o, alucontrol_o,
               imm_type_o, busy_o, err_o
`ifdef CU_ILLEGAL_TRAP_EN
        , illegal_o
`endif
    );
endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// cu_decoder: opcode/funct3/funct7 of the latched IR -> instruction class and legal flag.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic [6:0]   i_funct7,
    output instr_class_e o_class,
    output logic         o_legal
);
    always_comb begin
        o_class = CL_NOP;
        case (i_opcode)
            OPCODE_R: begin
                if (i_funct3 == 3'b000 && i_funct7 == 7'h00)      o_class = CL_ADD;
                else if (i_funct3 == 3'b000 && i_funct7 == 7'h20) o_class = CL_SUB;
            end
            OPCODE_I:     if (i_funct3 == 3'b000) o_class = CL_ADDI;
            OPCODE_LOAD:  if (i_funct3 == 3'b010) o_class = CL_LW;
            OPCODE_STORE: if (i_funct3 == 3'b010) o_class = CL_SW;
            OPCODE_B: begin
                if (i_funct3 == 3'b000)      o_class = CL_BEQ;
                else if (i_funct3 == 3'b001) o_class = CL_BNE;
            end
            OPCODE_J:     o_class = CL_JAL;
            default:      o_class = CL_NOP;
        endcase
        o_legal = (o_class != CL_NOP);
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory-ack watchdog.
// Define CU_ILLEGAL_TRAP_EN to trap unsupported instructions (adds illegal_o); else they run as NOP.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    cu_if.master bus
);
    localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WaitW-1:0] LastWait = WaitW'(ACK_TIMEOUT - 1);

    cu_state_e             r_state;
    logic [WaitW-1:0]      r_wait;
    logic [6:0]            r_opcode;
    logic [2:0]            r_funct3;
    logic [6:0]            r_funct7;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
`ifdef CU_ILLEGAL_TRAP_EN
    logic                  r_illegal;
`endif

    instr_class_e w_class;
    logic         w_legal;
    logic         w_taken;
    logic         w_writes_rd;

    cu_decoder u_dec (
        .i_opcode (r_opcode),
        .i_funct3 (r_funct3),
        .i_funct7 (r_funct7),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_wait   <= '0;
            r_opcode <= '0;
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                FETCH: begin
                    // An ack on the deadline cycle still wins over the watchdog.
                    if (bus.imem_ack_i) begin
                        r_opcode <= bus.instr_i[6:0];
                        r_rd     <= REG_ADDR_W'(bus.instr_i[11:7]);
                        r_funct3 <= bus.instr_i[14:12];
                        r_rs1    <= REG_ADDR_W'(bus.instr_i[19:15]);
                        r_rs2    <= REG_ADDR_W'(bus.instr_i[24:20]);
                        r_funct7 <= bus.instr_i[31:25];
                        r_wait   <= '0;
                        r_state  <= DECODE;
                    end else if (r_wait == LastWait) begin
                        r_wait  <= '0;
                        r_state <= ERROR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                DECODE: begin
                    if (w_legal) begin
                        r_state <= EXECUTE;
                    end else begin
`ifdef CU_ILLEGAL_TRAP_EN
                        r_illegal <= 1'b1;
                        r_state   <= ERROR;
`else
                        r_state <= WB;
`endif
                    end
                end
                EXECUTE: begin
                    case (w_class)
                        CL_BEQ, CL_BNE: r_state <= FETCH;
                        CL_LW, CL_SW:   r_state <= MEM;
                        default:        r_state <= WB;
                    endcase
                end
                MEM: begin
                    if (bus.dmem_ack_i) begin
                        r_wait  <= '0;
                        r_state <= (w_class == CL_LW) ? WB : FETCH;
                    end else if (r_wait == LastWait) begin
                        r_wait  <= '0;
                        r_state <= ERROR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                WB:      r_state <= FETCH;
                ERROR:   r_state <= ERROR;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign w_taken     = (w_class == CL_BEQ) ? bus.alu_zero_i : !bus.alu_zero_i;
    assign w_writes_rd = w_class inside {CL_ADD, CL_SUB, CL_ADDI, CL_LW, CL_JAL};

    // Decoded from registered state/IR only; ack and zero gate the same-cycle strobes,
    // and rst_n forces everything low immediately.
    always_comb begin
        bus.imem_req_o   = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.pc_write_o   = 1'b0;
        bus.pc_sel_o     = PC_4;
        bus.regwrite_o   = 1'b0;
        bus.rd_o         = '0;
        bus.rs1_o        = '0;
        bus.rs2_o        = '0;
        bus.memread_o    = 1'b0;
        bus.memwrite_o   = 1'b0;
        bus.memtoreg_o   = 1'b0;
        bus.alusrc_r1_o  = 1'b0;
        bus.alusrc_r2_o  = 1'b0;
        bus.alucontrol_o = ALU_CTRL_W'(ALU_ADD);
        bus.imm_type_o   = IMM_NF;
        bus.busy_o       = 1'b0;
        bus.err_o        = 1'b0;
        if (rst_n) begin
            if (r_state != ERROR) begin
                bus.rd_o  = r_rd;
                bus.rs1_o = r_rs1;
                bus.rs2_o = r_rs2;
            end
            bus.busy_o = (r_state != FETCH) && (r_state != ERROR);
            case (r_state)
                FETCH: begin
                    bus.imem_req_o = 1'b1;
                    bus.ir_write_o = bus.imem_ack_i;
                end
                DECODE: bus.imm_type_o = imm_of_class(w_class);
                EXECUTE: begin
                    bus.imm_type_o = imm_of_class(w_class);
                    case (w_class)
                        CL_SUB:  bus.alucontrol_o = ALU_CTRL_W'(ALU_SUB);
                        CL_ADDI, CL_LW, CL_SW: bus.alusrc_r2_o = 1'b1;
                        CL_BEQ, CL_BNE: begin
                            bus.alucontrol_o = ALU_CTRL_W'(ALU_SUB);
                            bus.pc_write_o   = 1'b1;
                            bus.pc_sel_o     = w_taken ? PC_BRANCH : PC_4;
                        end
                        CL_JAL:  bus.alusrc_r1_o = 1'b1;
                        default: ;
                    endcase
                end
                MEM: begin
                    bus.memread_o  = (w_class == CL_LW);
                    bus.memwrite_o = (w_class == CL_SW);
                    bus.pc_write_o = (w_class == CL_SW) && bus.dmem_ack_i;
                end
                WB: begin
                    bus.regwrite_o = w_writes_rd && (r_rd != '0);
                    bus.memtoreg_o = (w_class == CL_LW);
                    bus.pc_write_o = 1'b1;
                    bus.pc_sel_o   = (w_class == CL_JAL) ? PC_JUMP : PC_4;
                end
                ERROR:   bus.err_o = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    assign bus.illegal_o = rst_n & r_illegal;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: driver pushes expected retire records, monitor pops them on each pc_write.
module tb_multicycle_control_unit;
    import cu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cu_if #(.REG_ADDR_W(5), .ALU_CTRL_W(4)) bus ();

    multicycle_control_unit #(
        .REG_ADDR_W  (5),
        .ALU_CTRL_W  (4),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int pc_sel; int rw; int mtr; int rd; int lat; int mem; int imm; int alu; int r1; int r2;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic exp_t ex(int pc_sel, int rw, int mtr, int rd, int lat, int mem,
                                int imm, int alu, int r1, int r2);
        exp_t e;
        e.pc_sel = pc_sel; e.rw = rw; e.mtr = mtr; e.rd = rd; e.lat = lat;
        e.mem = mem; e.imm = imm; e.alu = alu; e.r1 = r1; e.r2 = r2;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: tracks one instruction from ir_write to its pc_write.
    bit m_act = 1'b0;
    int m_cnt, m_mem, m_imm, m_alu, m_r1, m_r2;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (bus.ir_write_o) begin
            m_act = 1'b1; m_cnt = 0; m_mem = 0; m_imm = 0; m_alu = 0; m_r1 = 0; m_r2 = 0;
        end else if (m_act) begin
            m_cnt++;
            if (m_cnt == 1) m_imm = int'(bus.imm_type_o);
            if (m_cnt == 2) begin
                m_alu = int'(bus.alucontrol_o);
                m_r1  = int'(bus.alusrc_r1_o);
                m_r2  = int'(bus.alusrc_r2_o);
            end
            if (bus.memread_o || bus.memwrite_o) m_mem++;
            if (bus.pc_write_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got retire expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pc_sel",   int'(bus.pc_sel_o),   e.pc_sel);
                    chk("regwrite", int'(bus.regwrite_o), e.rw);
                    chk("memtoreg", int'(bus.memtoreg_o), e.mtr);
                    chk("rd",       int'(bus.rd_o),       e.rd);
                    chk("latency",  m_cnt,                e.lat);
                    chk("mem_cyc",  m_mem,                e.mem);
                    chk("imm_type", m_imm,                e.imm);
                    chk("aluctrl",  m_alu,                e.alu);
                    chk("alusrc1",  m_r1,                 e.r1);
                    chk("alusrc2",  m_r2,                 e.r2);
                end
                m_act = 1'b0;
            end
        end
    end

    task automatic run(input logic [31:0] ins, input int ack_dly, input bit zero,
                       input int mem_dly, input exp_t e, input bit push);
        int n;
        if (push) sb.push_back(e);
        n = 0;
        while (!bus.imem_req_o && n < 100) begin step(); n++; end
        if (!bus.imem_req_o) begin
            checks++; failures++;
            $display("FAIL imem_req_timeout: got 0 expected 1");
            return;
        end
        bus.alu_zero_i = zero;
        repeat (ack_dly) step();
        bus.instr_i    = ins;
        bus.imem_ack_i = 1'b1;
        step();
        bus.imem_ack_i = 1'b0;
        bus.instr_i    = 32'hFFFF_FFFF;
        if (mem_dly > 0) begin
            n = 0;
            while (!(bus.memread_o || bus.memwrite_o) && n < 100) begin step(); n++; end
            if (!(bus.memread_o || bus.memwrite_o)) begin
                checks++; failures++;
                $display("FAIL dmem_req_timeout: got 0 expected 1");
                return;
            end
            repeat (mem_dly - 1) step();
            bus.dmem_ack_i = 1'b1;
            step();
            bus.dmem_ack_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin step(); n++; end
        chk("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.instr_i = '0; bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0; bus.alu_zero_i = 1'b0;
        #12;
        chk("rst_imem_req", int'(bus.imem_req_o), 0);
        chk("rst_busy",     int'(bus.busy_o),     0);
        chk("rst_err",      int'(bus.err_o),      0);
        chk("rst_pc_sel",   int'(bus.pc_sel_o),   0);
        chk("rst_imm_type", int'(bus.imm_type_o), 0);
        chk("rst_rd",       int'(bus.rd_o),       0);
        step();
        rst_n = 1'b1;

        run(32'h002081B3, 2, 0, 0, ex(0, 1, 0, 3, 3, 0, IMM_NF, 0, 0, 0), 1); // ADD x3,x1,x2
        run(32'h40118233, 0, 0, 0, ex(0, 1, 0, 4, 3, 0, IMM_NF, 1, 0, 0), 1); // SUB x4,x3,x1
        run(32'h00508393, 1, 0, 0, ex(0, 1, 0, 7, 3, 0, IMM_I,  0, 0, 1), 1); // ADDI x7,x1,5
        run(32'h00100013, 0, 0, 0, ex(0, 0, 0, 0, 3, 0, IMM_I,  0, 0, 1), 1); // ADDI x0,x0,1
        run(32'h00208063, 0, 1, 0, ex(1, 0, 0, 0, 2, 0, IMM_B,  1, 0, 0), 1); // BEQ taken
        run(32'h00208063, 1, 0, 0, ex(0, 0, 0, 0, 2, 0, IMM_B,  1, 0, 0), 1); // BEQ not taken
        run(32'h00209063, 0, 0, 0, ex(1, 0, 0, 0, 2, 0, IMM_B,  1, 0, 0), 1); // BNE taken
        run(32'h00209063, 0, 1, 0, ex(0, 0, 0, 0, 2, 0, IMM_B,  1, 0, 0), 1); // BNE not taken
        run(32'h0000A283, 0, 0, 4, ex(0, 1, 1, 5, 7, 4, IMM_I,  0, 0, 1), 1); // LW x5,0(x1)
        run(32'h0020A023, 3, 0, 1, ex(0, 0, 0, 0, 3, 1, IMM_S,  0, 0, 1), 1); // SW x2,0(x1)
        run(32'h000000EF, 0, 0, 0, ex(2, 1, 0, 1, 3, 0, IMM_J,  0, 1, 0), 1); // JAL x1
`ifdef CU_ILLEGAL_TRAP_EN
        drain();
        run(32'h0000007F, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        repeat (2) step();
        chk("illegal_err",  int'(bus.err_o),     1);
        chk("illegal_flag", int'(bus.illegal_o), 1);
        restart();
        chk("illegal_clr",  int'(bus.illegal_o), 0);
`else
        run(32'h0000007F, 0, 0, 0, ex(0, 0, 0, 0, 2, 0, IMM_NF, 0, 0, 0), 1); // opcode 7F NOP
        run(32'h022081B3, 0, 0, 0, ex(0, 0, 0, 3, 2, 0, IMM_NF, 0, 0, 0), 1); // bad funct7 NOP
        drain();
`endif

        // Watchdog: no fetch ack at all.
        restart();
        repeat (15) step();
        chk("wd_err_before", int'(bus.err_o),      0);
        chk("wd_req_before", int'(bus.imem_req_o), 1);
        step();
        chk("wd_err_at",     int'(bus.err_o),      1);
        chk("wd_req_at",     int'(bus.imem_req_o), 0);
        chk("wd_busy_at",    int'(bus.busy_o),     0);
        repeat (3) step();
        chk("wd_err_sticky", int'(bus.err_o),      1);
        rst_n = 1'b0;
        #1;
        chk("wd_err_async_clr", int'(bus.err_o), 0);
        step();
        rst_n = 1'b1;

        // Ack on the deadline cycle beats the watchdog.
        repeat (15) step();
        sb.push_back(ex(0, 1, 0, 3, 3, 0, IMM_NF, 0, 0, 0));
        bus.instr_i    = 32'h002081B3;
        bus.imem_ack_i = 1'b1;
        step();
        bus.imem_ack_i = 1'b0;
        chk("deadline_ack_err",  int'(bus.err_o),  0);
        chk("deadline_ack_busy", int'(bus.busy_o), 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
